ifu_fetch: RTL and testbench
============================

IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter CPU_WIDTH SHALL default to 32; it is the datapath width for PC, address and instruction.
REQ-002 Parameter RESET_PC SHALL default to 32'h8000_0000; it is the PC value loaded at reset.
REQ-003 i_clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 i_rst  in  1  reset, synchronous and active-low.
REQ-005 o_imem_req_valid  out  1  instruction-memory fetch request valid.
REQ-006 i_imem_req_ready  in  1  instruction memory accepts the request.
REQ-007 o_imem_req_addr  out  CPU_WIDTH  fetch address, equal to the current PC.
REQ-008 i_imem_rsp_valid  in  1  fetch response valid; this is a single-cycle pulse with no backpressure.
REQ-009 i_imem_rsp_data  in  CPU_WIDTH  fetched instruction word.
REQ-010 i_imem_rsp_err  in  1  bus error, qualified by i_imem_rsp_valid.
REQ-011 o_ifu_valid  out  1  instruction available to the IDU.
REQ-012 i_idu_ready  in  1  IDU accepts the instruction.
REQ-013 o_ifu_inst  out  CPU_WIDTH  latched instruction.
REQ-014 o_ifu_pc  out  CPU_WIDTH  PC of the latched instruction.
REQ-015 i_wb_commit  in  1  the in-flight instruction retires this cycle; i_bru_next_pc is valid.
REQ-016 i_bru_next_pc  in  CPU_WIDTH  next PC from the branch unit (jal/jalr/branch/PC+4).
REQ-017 o_ifu_fault  out  1  sticky fetch fault flag.
REQ-018 o_fault_cause  out  2  fault cause: 00 none, 01 bus error, 10 misaligned next PC.

Function
REQ-019 The block SHALL implement a registered FSM with states REQ, WAIT, DELIV, EXEC and FAULT; exactly one instruction is in flight at a time.
REQ-020 In REQ, o_imem_req_valid SHALL be 1 and o_imem_req_addr SHALL equal PC.
 - On i_imem_req_ready=1, the next state SHALL be WAIT.
 - Otherwise the FSM SHALL stay in REQ with valid and address held stable.
REQ-021 In WAIT, on i_imem_rsp_valid=1:
 - With i_imem_rsp_err=0: latch i_imem_rsp_data into o_ifu_inst and go to DELIV.
 - With i_imem_rsp_err=1: set cause 01 and go to FAULT.
REQ-022 A response with i_imem_rsp_valid=1 in the same cycle as request acceptance SHALL be ignored; a response can arrive at the earliest one cycle after acceptance.
REQ-023 In DELIV, o_ifu_valid SHALL be 1.
 - o_ifu_inst and o_ifu_pc SHALL be stable until i_idu_ready=1, then the next state SHALL be EXEC.
REQ-024 In EXEC, on i_wb_commit=1:
 - If i_bru_next_pc[1:0]==00: PC <= i_bru_next_pc and go to REQ.
 - Otherwise: PC SHALL be unchanged, cause SHALL be set to 10, and the next state SHALL be FAULT.
REQ-025 i_imem_rsp_valid outside WAIT and i_wb_commit outside EXEC SHALL be ignored, with no state change.
REQ-026 FAULT SHALL be absorbing until reset.
 - o_ifu_fault=1 and all valid outputs are 0.
 - o_ifu_pc holds the faulting PC.
REQ-027 Minimum latency from REQ handshake to o_ifu_valid SHALL be 2 cycles; from commit to the next o_imem_req_valid it SHALL be 1 cycle.
REQ-028 PC arithmetic SHALL be CPU_WIDTH-bit; the PC is only loaded from i_bru_next_pc, so wrap-around is the branch unit's responsibility and PC 32'hFFFF_FFFC is fetched normally.
REQ-029 o_ifu_pc SHALL always equal PC; o_imem_req_valid and o_ifu_valid SHALL be decoded from state only, with no combinational path from inputs.

Reset
REQ-030 While i_rst=0 at a clock edge, the following SHALL be loaded:
 - state <= REQ, PC <= RESET_PC;
 - o_ifu_inst <= 0, o_ifu_fault <= 0, o_fault_cause <= 00.
REQ-031 Reset SHALL take precedence over every other event in any state, including mid-WAIT; a stale response arriving after reset SHALL be ignored because the FSM is then in REQ.
REQ-032 In the first cycle after reset release, o_imem_req_valid SHALL be 1 with address RESET_PC.

Verification
REQ-033 Release reset with ready=1, respond after 1 cycle with 32'h00000013, IDU ready, commit next_pc=32'h80000004 -> second request address 32'h80000004; o_ifu_pc=32'h80000000 during the first DELIV.
REQ-034 Hold i_imem_req_ready=0 for 5 cycles -> o_imem_req_valid stays 1 and the address stays stable at 32'h80000000; no state advance.
REQ-035 i_idu_ready=0 for 3 cycles in DELIV -> o_ifu_valid=1 with o_ifu_inst unchanged; a spurious i_wb_commit during DELIV is ignored.
REQ-036 Commit with next_pc=32'h80000102 -> o_ifu_fault=1, cause 10, no further requests, o_ifu_pc=32'h80000000.
REQ-037 Response with err=1 -> cause 01 and FAULT; assert i_rst=0 for one cycle -> REQ at 32'h80000000 and fault cleared.
REQ-038 Assert reset in WAIT, then pulse rsp_valid in the cycle after release -> o_ifu_valid stays 0 and a fresh request is issued.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one instruction in flight, fetched from instruction
// memory, handed to the decoder, then held until writeback supplies the next PC.
module ifu_fetch #(
   parameter int unsigned           CPU_WIDTH = 32,
   parameter logic [CPU_WIDTH-1:0]  RESET_PC  = 32'h8000_0000
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   // instruction memory request
   output logic                  o_imem_req_valid,
   input  logic                  i_imem_req_ready,
   output logic [CPU_WIDTH-1:0]  o_imem_req_addr,
   // instruction memory response
   input  logic                  i_imem_rsp_valid,
   input  logic [CPU_WIDTH-1:0]  i_imem_rsp_data,
   input  logic                  i_imem_rsp_err,
   // decoder handoff
   output logic                  o_ifu_valid,
   input  logic                  i_idu_ready,
   output logic [CPU_WIDTH-1:0]  o_ifu_inst,
   output logic [CPU_WIDTH-1:0]  o_ifu_pc,
   // writeback / branch resolution
   input  logic                  i_wb_commit,
   input  logic [CPU_WIDTH-1:0]  i_bru_next_pc,
   // fault reporting
   output logic                  o_ifu_fault,
   output logic [1:0]            o_fault_cause
);

   localparam int unsigned CAUSE_W = 2;

   localparam logic [CAUSE_W-1:0] CAUSE_NONE  = 2'b00;
   localparam logic [CAUSE_W-1:0] CAUSE_BUS   = 2'b01;
   localparam logic [CAUSE_W-1:0] CAUSE_ALIGN = 2'b10;

   typedef enum logic [2:0] {
      ST_REQ   = 3'd0,
      ST_WAIT  = 3'd1,
      ST_DELIV = 3'd2,
      ST_EXEC  = 3'd3,
      ST_FAULT = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic [CPU_WIDTH-1:0]  pc_q, pc_d;
   logic [CPU_WIDTH-1:0]  inst_q, inst_d;
   logic                  fault_q, fault_d;
   logic [CAUSE_W-1:0]    cause_q, cause_d;

   // State and datapath registers; reset wins over every other event
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_q <= ST_REQ;
         pc_q    <= RESET_PC;
         inst_q  <= '0;
         fault_q <= 1'b0;
         cause_q <= CAUSE_NONE;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         fault_q <= fault_d;
         cause_q <= cause_d;
      end
   end

   // Next-state and datapath update; events outside their owning state are ignored
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      fault_d = fault_q;
      cause_d = cause_q;
      unique case (state_q)
         ST_REQ: begin
            if (i_imem_req_ready) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (i_imem_rsp_valid) begin
               if (i_imem_rsp_err) begin
                  state_d = ST_FAULT;
                  fault_d = 1'b1;
                  cause_d = CAUSE_BUS;
               end else begin
                  state_d = ST_DELIV;
                  inst_d  = i_imem_rsp_data;
               end
            end
         end
         ST_DELIV: begin
            if (i_idu_ready) begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (i_wb_commit) begin
               if (i_bru_next_pc[1:0] == 2'b00) begin
                  state_d = ST_REQ;
                  pc_d    = i_bru_next_pc;
               end else begin
                  state_d = ST_FAULT;
                  fault_d = 1'b1;
                  cause_d = CAUSE_ALIGN;
               end
            end
         end
         ST_FAULT: begin
            state_d = ST_FAULT;
         end
         default: begin
            state_d = ST_FAULT;
         end
      endcase
   end

   // Outputs decoded from registered state only
   always_comb begin
      o_imem_req_valid = (state_q == ST_REQ);
      o_ifu_valid      = (state_q == ST_DELIV);
      o_imem_req_addr  = pc_q;
      o_ifu_pc         = pc_q;
      o_ifu_inst       = inst_q;
      o_ifu_fault      = fault_q;
      o_fault_cause    = cause_q;
   end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed self-checking bench for ifu_fetch.
module tb_ifu_fetch;

   localparam int unsigned CPU_WIDTH = 32;

   logic                  clk;
   logic                  rst;
   logic                  req_valid;
   logic                  req_ready;
   logic [CPU_WIDTH-1:0]  req_addr;
   logic                  rsp_valid;
   logic [CPU_WIDTH-1:0]  rsp_data;
   logic                  rsp_err;
   logic                  ifu_valid;
   logic                  idu_ready;
   logic [CPU_WIDTH-1:0]  ifu_inst;
   logic [CPU_WIDTH-1:0]  ifu_pc;
   logic                  wb_commit;
   logic [CPU_WIDTH-1:0]  bru_next_pc;
   logic                  ifu_fault;
   logic [1:0]            fault_cause;

   int n_checks = 0;
   int n_fail   = 0;

   ifu_fetch #(
      .CPU_WIDTH (CPU_WIDTH),
      .RESET_PC  (32'h8000_0000)
   ) dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .o_imem_req_valid (req_valid),
      .i_imem_req_ready (req_ready),
      .o_imem_req_addr  (req_addr),
      .i_imem_rsp_valid (rsp_valid),
      .i_imem_rsp_data  (rsp_data),
      .i_imem_rsp_err   (rsp_err),
      .o_ifu_valid      (ifu_valid),
      .i_idu_ready      (idu_ready),
      .o_ifu_inst       (ifu_inst),
      .o_ifu_pc         (ifu_pc),
      .i_wb_commit      (wb_commit),
      .i_bru_next_pc    (bru_next_pc),
      .o_ifu_fault      (ifu_fault),
      .o_fault_cause    (fault_cause)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expected value
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: inputs take effect at the rising edge, outputs sampled at the falling edge
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step();
      rst = 1'b1;
   endtask

   // Request accepted, response one cycle later
   task automatic fetch(input logic [CPU_WIDTH-1:0] data, input logic err);
      req_ready = 1'b1;
      step();
      req_ready = 1'b0;
      rsp_valid = 1'b1;
      rsp_data  = data;
      rsp_err   = err;
      step();
      rsp_valid = 1'b0;
      rsp_err   = 1'b0;
   endtask

   task automatic deliver();
      idu_ready = 1'b1;
      step();
      idu_ready = 1'b0;
   endtask

   task automatic commit(input logic [CPU_WIDTH-1:0] npc);
      wb_commit   = 1'b1;
      bru_next_pc = npc;
      step();
      wb_commit   = 1'b0;
   endtask

   initial begin
      rst = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0; rsp_err = 1'b0;
      idu_ready = 1'b0; wb_commit = 1'b0; bru_next_pc = '0;
      @(negedge clk);
      step();
      step();
      chk("rst_req_valid", 64'(req_valid), 64'd1);
      chk("rst_addr",      64'(req_addr),  64'h8000_0000);
      chk("rst_ifu_valid", 64'(ifu_valid), 64'd0);
      chk("rst_inst",      64'(ifu_inst),  64'd0);
      chk("rst_fault",     64'(ifu_fault), 64'd0);
      chk("rst_cause",     64'(fault_cause), 64'd0);
      rst = 1'b1;

      // request held with no ready
      for (int i = 0; i < 5; i++) begin
         step();
         chk("hold_req_valid", 64'(req_valid), 64'd1);
         chk("hold_addr",      64'(req_addr),  64'h8000_0000);
      end

      // response coinciding with acceptance is ignored
      req_ready = 1'b1; rsp_valid = 1'b1; rsp_data = 32'hDEAD_BEEF;
      step();
      req_ready = 1'b0; rsp_data = 32'h0000_0013;
      chk("wait_req_valid", 64'(req_valid), 64'd0);
      chk("wait_ifu_valid", 64'(ifu_valid), 64'd0);
      step();
      rsp_valid = 1'b0;
      chk("deliv_valid", 64'(ifu_valid), 64'd1);
      chk("deliv_inst",  64'(ifu_inst),  64'h0000_0013);
      chk("deliv_pc",    64'(ifu_pc),    64'h8000_0000);

      // decoder stall with spurious commit
      for (int i = 0; i < 3; i++) begin
         wb_commit = (i == 0); bru_next_pc = 32'h8000_0040;
         step();
         chk("stall_valid", 64'(ifu_valid), 64'd1);
         chk("stall_inst",  64'(ifu_inst),  64'h0000_0013);
         chk("stall_pc",    64'(ifu_pc),    64'h8000_0000);
      end
      wb_commit = 1'b0;

      deliver();
      chk("exec_ifu_valid", 64'(ifu_valid), 64'd0);
      chk("exec_req_valid", 64'(req_valid), 64'd0);
      rsp_valid = 1'b1; rsp_data = 32'h0000_FFFF;
      step();
      rsp_valid = 1'b0;
      chk("exec_stray_rsp_inst", 64'(ifu_inst), 64'h0000_0013);
      chk("exec_stray_rsp_req",  64'(req_valid), 64'd0);

      commit(32'h8000_0004);
      chk("next_req_valid", 64'(req_valid), 64'd1);
      chk("next_addr",      64'(req_addr),  64'h8000_0004);
      chk("next_pc",        64'(ifu_pc),    64'h8000_0004);

      // second instruction, then branch to the top of the address space
      fetch(32'h0010_0093, 1'b0);
      chk("i2_valid", 64'(ifu_valid), 64'd1);
      chk("i2_inst",  64'(ifu_inst),  64'h0010_0093);
      deliver();
      commit(32'hFFFF_FFFC);
      chk("top_req_valid", 64'(req_valid), 64'd1);
      chk("top_addr",      64'(req_addr),  64'hFFFF_FFFC);
      fetch(32'h0000_0033, 1'b0);
      chk("top_inst", 64'(ifu_inst), 64'h0000_0033);
      chk("top_pc",   64'(ifu_pc),   64'hFFFF_FFFC);

      // misaligned next PC
      do_reset();
      chk("rst2_addr", 64'(req_addr), 64'h8000_0000);
      chk("rst2_inst", 64'(ifu_inst), 64'd0);
      fetch(32'h0000_0013, 1'b0);
      deliver();
      commit(32'h8000_0102);
      chk("mis_fault",     64'(ifu_fault),   64'd1);
      chk("mis_cause",     64'(fault_cause), 64'd2);
      chk("mis_req_valid", 64'(req_valid),   64'd0);
      chk("mis_ifu_valid", 64'(ifu_valid),   64'd0);
      chk("mis_pc",        64'(ifu_pc),      64'h8000_0000);
      req_ready = 1'b1; rsp_valid = 1'b1; rsp_err = 1'b1; idu_ready = 1'b1;
      wb_commit = 1'b1; bru_next_pc = 32'h8000_0008;
      step();
      step();
      req_ready = 1'b0; rsp_valid = 1'b0; rsp_err = 1'b0; idu_ready = 1'b0; wb_commit = 1'b0;
      chk("abs_fault",     64'(ifu_fault),   64'd1);
      chk("abs_cause",     64'(fault_cause), 64'd2);
      chk("abs_req_valid", 64'(req_valid),   64'd0);
      chk("abs_ifu_valid", 64'(ifu_valid),   64'd0);
      chk("abs_pc",        64'(ifu_pc),      64'h8000_0000);

      // bus error
      do_reset();
      chk("rst3_fault",     64'(ifu_fault),   64'd0);
      chk("rst3_cause",     64'(fault_cause), 64'd0);
      chk("rst3_req_valid", 64'(req_valid),   64'd1);
      fetch(32'h1234_5678, 1'b1);
      chk("bus_fault",     64'(ifu_fault),   64'd1);
      chk("bus_cause",     64'(fault_cause), 64'd1);
      chk("bus_ifu_valid", 64'(ifu_valid),   64'd0);
      chk("bus_inst",      64'(ifu_inst),    64'd0);
      do_reset();
      chk("rst4_fault",     64'(ifu_fault),   64'd0);
      chk("rst4_cause",     64'(fault_cause), 64'd0);
      chk("rst4_req_valid", 64'(req_valid),   64'd1);
      chk("rst4_addr",      64'(req_addr),    64'h8000_0000);

      // reset in WAIT, stale response right after release
      req_ready = 1'b1;
      step();
      req_ready = 1'b0;
      chk("w_req_valid", 64'(req_valid), 64'd0);
      do_reset();
      rsp_valid = 1'b1; rsp_data = 32'h0000_0055;
      step();
      rsp_valid = 1'b0;
      chk("stale_ifu_valid", 64'(ifu_valid), 64'd0);
      chk("stale_req_valid", 64'(req_valid), 64'd1);
      chk("stale_addr",      64'(req_addr),  64'h8000_0000);
      chk("stale_inst",      64'(ifu_inst),  64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
